// File: rtl/buffer_reader_if.sv
// Byte stream from the capture-buffer drain engine to the UART transmitter.
// Plain valid/ready: a byte moves on any rising edge where tx_valid and tx_ready are both high.
interface buffer_reader_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/buffer_reader.sv
// Drains the capture ring record by record, MSB byte first, onto a valid/ready byte stream.
// First byte is valid 3 cycles after IDLE sees data; tx_valid/tx_data hold until tx_ready.
module buffer_reader #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic [AW-1:0]   write_ptr,
  output logic [AW-1:0]   read_addr,
  input  logic [DW-1:0]   read_data,
  buffer_reader_if.master tx,
  output logic [AW-1:0]   level,
  output logic            busy
);

  localparam int NBYTES = DW / 8;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  // SEND owns bit 2 alone, so tx_valid comes straight off a state flop.
  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    FETCH = 3'b001,
    LATCH = 3'b010,
    SEND  = 3'b100
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [DW-1:0]   shift;
  logic [IW-1:0]   byte_idx;
  logic            empty;
  logic            last_byte;

  assign empty     = (read_addr == write_ptr);
  assign level     = write_ptr - read_addr;
  assign last_byte = (byte_idx == LAST_IDX);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable && !empty) state_nxt = FETCH;
      FETCH:   state_nxt = LATCH;
      LATCH:   state_nxt = SEND;
      SEND:    if (tx.tx_ready && last_byte) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx.tx_valid = state[2];
    tx.tx_data  = shift[DW-1 -: 8];
    busy        = (state != IDLE);
  end

  // read_data arrives during LATCH because the buffer registers it at the end of FETCH.
  always_ff @(posedge clock) begin
    if (reset) begin
      read_addr <= '0;
      shift     <= '0;
      byte_idx  <= '0;
    end else begin
      case (state)
        LATCH: begin
          shift    <= read_data;
          byte_idx <= '0;
        end
        SEND: begin
          if (tx.tx_ready) begin
            if (last_byte) begin
              read_addr <= read_addr + AW'(1);
            end else begin
              shift    <= shift << 8;
              byte_idx <= byte_idx + IW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_reader.sv
// Three drain engines (16-bit/256-deep, 8-bit/4-deep, 32-bit/256-deep) against ring models and byte scoreboards.
module tb_buffer_reader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // ---------------- instance A: AW=8, DW=16
  logic        rst_a = 1'b1, en_a = 1'b0;
  logic [7:0]  wp_a = '0, addr_a, lvl_a;
  logic [15:0] rd_a;
  logic        busy_a;
  logic [15:0] ram_a [256];
  logic [7:0]  qa [$];
  int          extra_a = 0;
  buffer_reader_if if_a ();

  buffer_reader #(.AW(8), .DW(16)) u_a (
    .clock(clock), .reset(rst_a), .enable(en_a), .write_ptr(wp_a),
    .read_addr(addr_a), .read_data(rd_a), .tx(if_a.master),
    .level(lvl_a), .busy(busy_a));

  always @(posedge clock) rd_a <= ram_a[addr_a];

  // ---------------- instance B: AW=2, DW=8
  logic        rst_b = 1'b1, en_b = 1'b0;
  logic [1:0]  wp_b = '0, addr_b, lvl_b;
  logic [7:0]  rd_b;
  logic        busy_b;
  logic [7:0]  ram_b [4];
  logic [7:0]  qb [$];
  int          extra_b = 0;
  buffer_reader_if if_b ();

  buffer_reader #(.AW(2), .DW(8)) u_b (
    .clock(clock), .reset(rst_b), .enable(en_b), .write_ptr(wp_b),
    .read_addr(addr_b), .read_data(rd_b), .tx(if_b.master),
    .level(lvl_b), .busy(busy_b));

  always @(posedge clock) rd_b <= ram_b[addr_b];

  // ---------------- instance C: AW=8, DW=32
  logic        rst_c = 1'b1, en_c = 1'b0;
  logic [7:0]  wp_c = '0, addr_c, lvl_c;
  logic [31:0] rd_c;
  logic        busy_c;
  logic [31:0] ram_c [256];
  logic [7:0]  qc [$];
  int          extra_c = 0;
  buffer_reader_if if_c ();

  buffer_reader #(.AW(8), .DW(32)) u_c (
    .clock(clock), .reset(rst_c), .enable(en_c), .write_ptr(wp_c),
    .read_addr(addr_c), .read_data(rd_c), .tx(if_c.master),
    .level(lvl_c), .busy(busy_c));

  always @(posedge clock) rd_c <= ram_c[addr_c];

  // Scoreboards: a handshake is sampled mid-cycle, ahead of the edge that completes it.
  always @(negedge clock) begin
    if (rst_a) qa.delete();
    else if (if_a.tx_valid && if_a.tx_ready) begin
      if (qa.size() == 0) extra_a++;
      else check("a_byte", 32'(if_a.tx_data), 32'(qa.pop_front()));
    end
  end

  always @(negedge clock) begin
    if (rst_b) qb.delete();
    else if (if_b.tx_valid && if_b.tx_ready) begin
      if (qb.size() == 0) extra_b++;
      else check("b_byte", 32'(if_b.tx_data), 32'(qb.pop_front()));
    end
  end

  always @(negedge clock) begin
    if (rst_c) qc.delete();
    else if (if_c.tx_valid && if_c.tx_ready) begin
      if (qc.size() == 0) extra_c++;
      else check("c_byte", 32'(if_c.tx_data), 32'(qc.pop_front()));
    end
  end

  task automatic push_a(input logic [7:0] a, input logic [15:0] d);
    ram_a[a] = d;
    qa.push_back(d[15:8]);
    qa.push_back(d[7:0]);
  endtask

  task automatic push_b(input logic [1:0] a, input logic [7:0] d);
    ram_b[a] = d;
    qb.push_back(d);
  endtask

  task automatic push_c(input logic [7:0] a, input logic [31:0] d);
    ram_c[a] = d;
    for (int k = 3; k >= 0; k--) qc.push_back(d[k*8 +: 8]);
  endtask

  function automatic logic [7:0] addr_of(input int sel);
    case (sel)
      0:       return addr_a;
      1:       return {6'b0, addr_b};
      default: return addr_c;
    endcase
  endfunction

  task automatic wait_addr(input string tag, input int sel, input logic [7:0] target, input int max);
    int i = 0;
    while (i < max && addr_of(sel) !== target) begin
      tick(1);
      i++;
    end
    check(tag, 32'(addr_of(sel)), 32'(target));
  endtask

  initial begin
    if_a.tx_ready = 1'b0;
    if_b.tx_ready = 1'b0;
    if_c.tx_ready = 1'b0;
    tick(2);

    // ---- A: reset state
    check("a_rst_addr",  32'(addr_a),        32'd0);
    check("a_rst_valid", 32'(if_a.tx_valid), 32'd0);
    check("a_rst_data",  32'(if_a.tx_data),  32'd0);
    check("a_rst_busy",  32'(busy_a),        32'd0);
    check("a_rst_level", 32'(lvl_a),         32'd0);

    // ---- A: single record, ready held high
    rst_a = 1'b0; en_a = 1'b1; if_a.tx_ready = 1'b1;
    push_a(8'd0, 16'hA55A);
    wp_a = 8'd1;
    tick(1);
    check("a_fetch_busy",  32'(busy_a),        32'd1);
    check("a_fetch_valid", 32'(if_a.tx_valid), 32'd0);
    tick(1);
    check("a_latch_valid", 32'(if_a.tx_valid), 32'd0);
    tick(1);
    check("a_b0_valid", 32'(if_a.tx_valid), 32'd1);
    check("a_b0_data",  32'(if_a.tx_data),  32'hA5);
    tick(1);
    check("a_b1_valid", 32'(if_a.tx_valid), 32'd1);
    check("a_b1_data",  32'(if_a.tx_data),  32'h5A);
    check("a_b1_busy",  32'(busy_a),        32'd1);
    tick(1);
    check("a_done_valid", 32'(if_a.tx_valid), 32'd0);
    check("a_done_addr",  32'(addr_a),        32'd1);
    check("a_done_level", 32'(lvl_a),         32'd0);
    check("a_done_busy",  32'(busy_a),        32'd0);

    // ---- A: backpressure holds byte 0
    if_a.tx_ready = 1'b0;
    push_a(8'd1, 16'hA55A);
    wp_a = 8'd2;
    tick(3);
    for (int i = 0; i < 5; i++) begin
      check("a_hold_valid", 32'(if_a.tx_valid), 32'd1);
      check("a_hold_data",  32'(if_a.tx_data),  32'hA5);
      tick(1);
    end
    if_a.tx_ready = 1'b1;
    tick(1);
    check("a_bp_b1_data", 32'(if_a.tx_data), 32'h5A);
    tick(1);
    check("a_bp_addr", 32'(addr_a), 32'd2);

    // ---- A: enable dropped mid-record
    rst_a = 1'b1; wp_a = 8'd0;
    tick(1);
    rst_a = 1'b0;
    for (int i = 0; i < 4; i++) push_a(8'(i), 16'($urandom));
    wp_a = 8'd4;
    wait_addr("a_rec1_done", 0, 8'd1, 20);
    for (int i = 0; i < 20 && !if_a.tx_valid; i++) tick(1);
    check("a_rec2_sending", 32'(if_a.tx_valid), 32'd1);
    en_a = 1'b0;
    wait_addr("a_rec2_done", 0, 8'd2, 20);
    tick(6);
    check("a_paused_addr",  32'(addr_a),        32'd2);
    check("a_paused_level", 32'(lvl_a),         32'd2);
    check("a_paused_busy",  32'(busy_a),        32'd0);
    check("a_paused_valid", 32'(if_a.tx_valid), 32'd0);
    en_a = 1'b1;
    wait_addr("a_resume", 0, 8'd4, 40);
    check("a_resume_level", 32'(lvl_a), 32'd0);

    // ---- B: wrap from address 3 through 0
    rst_b = 1'b0; en_b = 1'b1; if_b.tx_ready = 1'b1;
    push_b(2'd0, 8'h11);
    push_b(2'd1, 8'h22);
    push_b(2'd2, 8'h33);
    wp_b = 2'd3;
    wait_addr("b_pre_drain", 1, 8'd3, 40);
    push_b(2'd3, 8'h44);
    push_b(2'd0, 8'h11);
    wp_b = 2'd1;
    wait_addr("b_wrap0", 1, 8'd0, 20);
    wait_addr("b_wrap1", 1, 8'd1, 20);
    check("b_level", 32'(lvl_b), 32'd0);

    // ---- C: level tracking
    rst_c = 1'b0; en_c = 1'b0; if_c.tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_c(8'(i), $urandom);
    wp_c = 8'd5;
    tick(1);
    check("c_level5", 32'(lvl_c), 32'd5);
    en_c = 1'b1;
    wait_addr("c_first_done", 2, 8'd1, 20);
    en_c = 1'b0;
    check("c_level4", 32'(lvl_c), 32'd4);
    tick(3);
    check("c_idle_busy", 32'(busy_c), 32'd0);

    // ---- C: reset while byte 0 is pending
    en_c = 1'b1; if_c.tx_ready = 1'b0;
    for (int i = 0; i < 20 && !if_c.tx_valid; i++) tick(1);
    check("c_pend_valid", 32'(if_c.tx_valid), 32'd1);
    check("c_pend_data",  32'(if_c.tx_data),  32'(ram_c[1][31:24]));
    rst_c = 1'b1; wp_c = 8'd0;
    tick(1);
    check("c_rst_valid", 32'(if_c.tx_valid), 32'd0);
    check("c_rst_data",  32'(if_c.tx_data),  32'd0);
    check("c_rst_addr",  32'(addr_c),        32'd0);
    check("c_rst_busy",  32'(busy_c),        32'd0);
    rst_c = 1'b0; if_c.tx_ready = 1'b1;
    tick(10);
    check("c_post_valid", 32'(if_c.tx_valid), 32'd0);
    check("c_post_busy",  32'(busy_c),        32'd0);

    // ---- leftovers
    check("a_queue_left", 32'(qa.size()), 32'd0);
    check("b_queue_left", 32'(qb.size()), 32'd0);
    check("a_extra",      32'(extra_a),   32'd0);
    check("b_extra",      32'(extra_b),   32'd0);
    check("c_extra",      32'(extra_c),   32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/buffer_reader.md
Name: buffer_reader

Overview:
- Read-side drain engine for the dual-port capture buffer.
- Single clock domain, shared with the writer port of the buffer.
- Compares its own read pointer against the writer's published write pointer and fetches each stored DW-bit record through the buffer's registered read port.
- Serialises each record MSB-byte-first onto a byte valid/ready stream feeding the UART transmitter.

Parameters:
AW, 8, buffer address width; ring depth is 2^AW entries
DW, 8, record width in bits; must be a multiple of 8 and >= 8; NBYTES = DW/8

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  when high, new record fetches may start
write_ptr  input  AW  writer's next-free address; entries read_addr..write_ptr-1 (mod 2^AW) are valid
read_addr  output  AW  address to the buffer read port; also the reader's pointer for the writer's full check
read_data  input  DW  buffer read port data, registered inside the buffer (1-cycle latency)
tx_data  output  8  byte to the transmitter
tx_valid  output  1  tx_data holds a valid byte
tx_ready  input  1  transmitter accepts the byte this cycle
level  output  AW  occupancy = (write_ptr - read_addr) mod 2^AW, combinational
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: read_addr=0, tx_data=0, tx_valid=0, busy=0, state=IDLE, byte index=0, shift register=0.
- Empty condition: read_addr == write_ptr.
- Full/lap detection is the writer's responsibility, based on read_addr.
- State IDLE: if enable && !empty, go to FETCH; otherwise stay.
- State FETCH: read_addr is already stable on the port. The buffer registers read_data at the end of this cycle. Go to LATCH.
- State LATCH: shift register <= read_data; byte index <= 0; go to SEND.
- State SEND:
  - tx_valid=1; tx_data = shift[DW-1:DW-8].
  - On tx_ready with byte index < NBYTES-1: shift left by 8, increment index, stay in SEND. tx_valid stays high, so back-to-back bytes are possible.
  - On tx_ready with byte index == NBYTES-1: read_addr <= read_addr+1 (wraps 2^AW-1 -> 0); tx_valid <= 0; go to IDLE.
- tx_valid and tx_data are registered outputs.
- Handshake rules:
  - Once tx_valid is high, tx_valid and tx_data stay unchanged until tx_ready is sampled high.
  - tx_ready while tx_valid=0 is ignored.
  - tx_valid never drops without a transfer, except on reset.
- Latency: from IDLE sampling non-empty at cycle N, the first byte is valid at cycle N+3.
- Throughput: with tx_ready held high, a record costs NBYTES+3 cycles (IDLE, FETCH, LATCH, NBYTES x SEND).
- enable:
  - Gates only the IDLE->FETCH transition.
  - Deasserting enable mid-record does not abort; the current record completes.
- write_ptr changes during FETCH/LATCH/SEND do not affect the record in flight; they are re-evaluated in IDLE.
- read_addr changes only on the final byte handshake. It never advances past write_ptr, because a fetch requires non-empty.
- Reset mid-record (synchronous): the partial record is discarded and all outputs return to reset values on the next edge. The writer is reset by the same signal.
- Arithmetic: level and the read_addr increment are AW-bit modulo 2^AW; no carry is kept.
- Consequence: a completely full ring (write_ptr == read_addr after a lap) reads as empty. The writer keeps at most 2^AW-1 entries.

Test Plan:
- DW=16, AW=8, ram[0]=16'hA55A, write_ptr=1, tx_ready=1, enable=1 -> tx_valid rises 3 cycles after IDLE; bytes 8'hA5 then 8'h5A on consecutive cycles; read_addr=1; level=0; busy drops the cycle after.
- Same record, tx_ready=0 for 5 cycles after tx_valid rises -> tx_valid=1 and tx_data=8'hA5 held stable for all 5 cycles; A5 transfers on the first tx_ready=1, 5A follows.
- AW=2, DW=8, ram={11,22,33,44}, read_addr=3 via prior drains, write_ptr=1 -> bytes 8'h44 then 8'h11 emitted; read_addr wraps 3->0->1; level=0.
- write_ptr=4, enable dropped during the second record's SEND -> second record completes; read_addr=2, level=2, state stays IDLE; re-asserting enable resumes at addr 2.
- reset pulsed while byte 0 of a DW=32 record is pending -> next cycle tx_valid=0, tx_data=0, read_addr=0, busy=0; no partial bytes emitted afterwards.
- write_ptr=5, read_addr=0 -> level=5; after one record drains -> level=4.
